// File: rtl/maint_pkg.sv
// Shared types and constants for the maintenance watchdog controller.
package maint_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    HIT   = 3'd2,
    ERROR = 3'd3,
    CLEAR = 3'd4
  } state_t;

  localparam logic [7:0] ERR_CODE  = 8'hFF;
  localparam logic [7:0] PRESS_MAX = 8'hFE;

endpackage

// File: rtl/maint_timer.sv
// Timeout timer: 8-bit counter with clear/enable; flags the last cycle before expiry.
module maint_timer #(
  parameter int unsigned TIMEOUT = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired = (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/maint_watchdog_ctrl.sv
// Maintenance watchdog: counts button presses, raises a latched error code after a
// press-free timeout, and clears it on an acknowledging press.
module maint_watchdog_ctrl
  import maint_pkg::*;
#(
  parameter int unsigned TIMEOUT = 100,
  parameter int unsigned ERR_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             enable,
  output logic [2:0]       current_state,
  output logic [7:0]       reg_state,
  output logic [7:0]       press_count,
  output logic             error_flag,
  output logic [ERR_W-1:0] error_count
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t           state_q, state_d;
  logic             x_d, press_q, expired, expired_q, timer_run;
  logic [7:0]       press_count_q, press_count_d, reg_state_q, reg_state_d;
  logic [ERR_W-1:0] error_count_q, error_count_d;
  logic             error_flag_q, error_flag_d;

  assign timer_run = (state_q == WAIT);

  maint_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!timer_run),
    .en     (timer_run),
    .expired(expired)
  );

  // Press and expiry are registered; edges seen while IDLE (incl. the first
  // post-reset edge) are discarded so a button held through reset never counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_d       <= 1'b0;
      press_q   <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      x_d       <= x;
      press_q   <= x & ~x_d & (state_q != IDLE);
      expired_q <= expired & timer_run;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      press_count_q <= '0;
      error_count_q <= '0;
      reg_state_q   <= '0;
      error_flag_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      press_count_q <= press_count_d;
      error_count_q <= error_count_d;
      reg_state_q   <= reg_state_d;
      error_flag_q  <= error_flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (enable) state_d = WAIT;
      WAIT: begin
        if (!enable)        state_d = IDLE;
        else if (press_q)   state_d = HIT;
        else if (expired_q) state_d = ERROR;
      end
      HIT:   state_d = enable ? WAIT : IDLE;
      ERROR: if (press_q) state_d = CLEAR;
      CLEAR: state_d = enable ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    press_count_d = press_count_q;
    error_count_d = error_count_q;
    if (state_d == HIT && state_q != HIT && press_count_q < PRESS_MAX) begin
      press_count_d = press_count_q + 8'd1;
    end
    if (state_d == ERROR && state_q != ERROR && error_count_q != ERR_MAX) begin
      error_count_d = error_count_q + 1'b1;
    end
    error_flag_d = (state_d == ERROR);
    reg_state_d  = (state_d == ERROR) ? ERR_CODE : press_count_d;
  end

  assign current_state = state_q;
  assign reg_state     = reg_state_q;
  assign press_count   = press_count_q;
  assign error_flag    = error_flag_q;
  assign error_count   = error_count_q;

endmodule

// File: tb/tb_maint_watchdog_ctrl.sv
// Directed bench for maint_watchdog_ctrl with TIMEOUT=10, ERR_W=4.
module tb_maint_watchdog_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       x = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] current_state;
  logic [7:0] reg_state;
  logic [7:0] press_count;
  logic       error_flag;
  logic [3:0] error_count;

  int passes = 0;
  int total  = 0;
  int first_err;

  maint_watchdog_ctrl #(
    .TIMEOUT(10),
    .ERR_W  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .x            (x),
    .enable       (enable),
    .current_state(current_state),
    .reg_state    (reg_state),
    .press_count  (press_count),
    .error_flag   (error_flag),
    .error_count  (error_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(current_state), 0);
    chk({tag, "_reg"},   32'(reg_state),     0);
    chk({tag, "_press"}, 32'(press_count),   0);
    chk({tag, "_eflag"}, 32'(error_flag),    0);
    chk({tag, "_ecnt"},  32'(error_count),   0);
  endtask

  // One press, four cycles: rise, HIT, back to WAIT, one idle cycle.
  task automatic press4();
    x = 1'b1; tick();
    x = 1'b0; tick(); tick(); tick();
  endtask

  // Let the timer expire, then acknowledge; ends one edge after returning to WAIT.
  task automatic err_ack();
    repeat (12) tick();
    x = 1'b1; tick();
    x = 1'b0; tick(); tick();
  endtask

  initial begin
    // Reset values
    #3;
    chk_reset("rst");
    tick(); tick();
    rst = 1'b1;
    enable = 1'b1;

    // 1: timeout after TIMEOUT+1 cycles
    tick();
    chk("t1_wait", 32'(current_state), 1);
    repeat (10) tick();
    chk("t1_pre_state", 32'(current_state), 1);
    chk("t1_pre_flag",  32'(error_flag),    0);
    tick();
    chk("t1_flag",  32'(error_flag),    1);
    chk("t1_reg",   32'(reg_state),     32'hFF);
    chk("t1_ecnt",  32'(error_count),   1);
    chk("t1_state", 32'(current_state), 3);

    // enable=0 is ignored in ERROR
    enable = 1'b0;
    tick(); tick();
    chk("t6_err_hold", 32'(current_state), 3);
    enable = 1'b1;
    x = 1'b1; tick();
    x = 1'b0; tick();
    chk("t1_clear",      32'(current_state), 4);
    chk("t1_clear_flag", 32'(error_flag),    0);
    chk("t1_clear_reg",  32'(reg_state),     0);
    tick();
    chk("t1_rewait", 32'(current_state), 1);

    // 2: three presses spaced five cycles
    for (int i = 1; i <= 3; i++) begin
      x = 1'b1; tick();
      x = 1'b0; tick();
      chk("t2_hit",   32'(current_state), 2);
      chk("t2_count", 32'(press_count),   32'(i));
      tick();
      chk("t2_back", 32'(current_state), 1);
      tick(); tick();
    end
    chk("t2_reg",  32'(reg_state),   3);
    chk("t2_ecnt", 32'(error_count), 1);

    // 3: button held high for 50 cycles counts once, then times out
    first_err = 0;
    x = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (error_flag && first_err == 0) first_err = i;
    end
    chk("t3_err_cycle", 32'(first_err),     14);
    chk("t3_count",     32'(press_count),   4);
    chk("t3_ecnt",      32'(error_count),   2);
    chk("t3_reg_err",   32'(reg_state),     32'hFF);
    x = 1'b0; tick();
    x = 1'b1; tick();
    x = 1'b0; tick();
    chk("t3_clear",       32'(current_state), 4);
    chk("t3_clear_count", 32'(press_count),   4);
    chk("t3_clear_reg",   32'(reg_state),     4);
    tick();
    chk("t3_rewait", 32'(current_state), 1);

    // 4: press arriving on the expiry cycle wins
    repeat (9) tick();
    x = 1'b1; tick();
    chk("t4_still_wait", 32'(current_state), 1);
    x = 1'b0; tick();
    chk("t4_hit",   32'(current_state), 2);
    chk("t4_count", 32'(press_count),   5);
    chk("t4_ecnt",  32'(error_count),   2);
    chk("t4_flag",  32'(error_flag),    0);
    tick();

    // 5: press_count saturates at 0xFE, error_count at 15
    for (int i = 0; i < 249; i++) press4();
    chk("t5_count_fe", 32'(press_count), 32'hFE);
    x = 1'b1; tick();
    x = 1'b0; tick();
    chk("t5_sat_hit",   32'(current_state), 2);
    chk("t5_sat_count", 32'(press_count),   32'hFE);
    chk("t5_sat_reg",   32'(reg_state),     32'hFE);
    tick(); tick();
    for (int i = 0; i < 13; i++) err_ack();
    chk("t5_ecnt_15", 32'(error_count), 15);
    for (int i = 0; i < 3; i++) err_ack();
    chk("t5_ecnt_sat",  32'(error_count),   15);
    chk("t5_count_kept", 32'(press_count),  32'hFE);

    // 6: asynchronous reset mid-HIT
    x = 1'b1; tick();
    x = 1'b0; tick();
    chk("t6_hit", 32'(current_state), 2);
    #2 rst = 1'b0;
    #1 chk_reset("t6_hit_rst");
    tick();
    rst = 1'b1;
    tick();
    repeat (12) tick();
    chk("t6_err", 32'(current_state), 3);

    // Reset in ERROR with the button held through release
    x = 1'b1;
    #2 rst = 1'b0;
    #1 chk_reset("t6_err_rst");
    tick(); tick();
    rst = 1'b1;
    tick();
    tick(); tick(); tick();
    chk("t6_held_state", 32'(current_state), 1);
    chk("t6_held_count", 32'(press_count),   0);
    x = 1'b0; tick();
    x = 1'b1; tick();
    x = 1'b0; tick();
    chk("t6_new_hit",   32'(current_state), 2);
    chk("t6_new_count", 32'(press_count),   1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
